servo_motion_sequencer: RTL and testbench



---
 rtl/servo_motion_sequencer.sv | 163 ++++++++++++++++
 tb/tb_servo_motion_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_motion_sequencer.sv
// servo_motion_sequencer: ramps the four arm servo angles to a commanded target
// set, one joint at a time in the safe order angle3, angle1, angle2, angle4.
// Optional feature macro: ANGLE_CLAMP_EN (saturate accepted targets to 180).
module servo_motion_sequencer #(
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned STEP_DEG      = 1,
    parameter int unsigned SETTLE_CYCLES = 1000000,
    parameter int unsigned HOME_ANGLE    = 90
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] tgt1,
    input  logic [7:0] tgt2,
    input  logic [7:0] tgt3,
    input  logic [7:0] tgt4,
    input  logic       abort,
    output logic [7:0] angle1,
    output logic [7:0] angle2,
    output logic [7:0] angle3,
    output logic [7:0] angle4,
    output logic       busy,
    output logic       done
);
    localparam int unsigned ANG_W = 8;
    localparam int unsigned DIF_W = 9;
    localparam int unsigned CNT_W = 32;
    localparam logic [ANG_W-1:0] HOME        = ANG_W'(HOME_ANGLE);
    localparam logic [DIF_W-1:0] STEP        = DIF_W'(STEP_DEG);
    localparam logic [CNT_W-1:0] TICK_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SETTLE, S_DONE} state_t;

    state_t                  r_state, w_state_nx;
    logic [1:0]              r_idx, w_idx_nx;
    logic [CNT_W-1:0]        r_tick, w_tick_nx;
    logic [CNT_W-1:0]        r_settle, w_settle_nx;
    logic [3:0][ANG_W-1:0]   r_ang, w_ang_nx;
    logic [3:0][ANG_W-1:0]   r_tgt, w_tgt_nx;
    logic                    r_cmd_ready, r_busy, r_done;
    logic [1:0]              w_sel;
    logic [DIF_W-1:0]        w_cur, w_dst, w_diff, w_step;
    logic                    w_up;
    logic [ANG_W-1:0]        w_stepped;

    // Target conditioning applied once, at command acceptance
    function automatic logic [ANG_W-1:0] cond_tgt(input logic [ANG_W-1:0] t);
`ifdef ANGLE_CLAMP_EN
        return (t > 8'd180) ? 8'd180 : t;
`else
        return t;
`endif
    endfunction

    // Map the joint index onto the angle slot: angle3, angle1, angle2, angle4
    always_comb begin
        case (r_idx)
            2'd0:    w_sel = 2'd2;
            2'd1:    w_sel = 2'd0;
            2'd2:    w_sel = 2'd1;
            default: w_sel = 2'd3;
        endcase
    end

    // Non-overshooting step of the active joint toward its target (9-bit, no wrap)
    always_comb begin
        w_cur     = DIF_W'(r_ang[w_sel]);
        w_dst     = DIF_W'(r_tgt[w_sel]);
        w_up      = (w_dst > w_cur);
        w_diff    = w_up ? (w_dst - w_cur) : (w_cur - w_dst);
        w_step    = (w_diff < STEP) ? w_diff : STEP;
        w_stepped = w_up ? ANG_W'(w_cur + w_step) : ANG_W'(w_cur - w_step);
    end

    // Next-state and next-datapath logic
    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_tick_nx   = r_tick;
        w_settle_nx = r_settle;
        w_ang_nx    = r_ang;
        w_tgt_nx    = r_tgt;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_tgt_nx[0] = cond_tgt(tgt1);
                    w_tgt_nx[1] = cond_tgt(tgt2);
                    w_tgt_nx[2] = cond_tgt(tgt3);
                    w_tgt_nx[3] = cond_tgt(tgt4);
                    w_idx_nx    = 2'd0;
                    w_tick_nx   = '0;
                    w_state_nx  = S_MOVE;
                end
            end
            S_MOVE: begin
                if (abort) begin
                    w_state_nx = S_IDLE;
                end else if (w_diff == '0) begin
                    w_tick_nx = '0;
                    if (r_idx == 2'd3) begin
                        w_settle_nx = '0;
                        w_state_nx  = S_SETTLE;
                    end else begin
                        w_idx_nx = r_idx + 2'd1;
                    end
                end else if (r_tick == TICK_LAST) begin
                    w_ang_nx[w_sel] = w_stepped;
                    w_tick_nx       = '0;
                end else begin
                    w_tick_nx = r_tick + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    w_state_nx = S_IDLE;
                end else if (r_settle == SETTLE_LAST) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_settle_nx = r_settle + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State register, datapath registers and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_tick      <= '0;
            r_settle    <= '0;
            r_ang       <= {4{HOME}};
            r_tgt       <= {4{HOME}};
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_idx       <= w_idx_nx;
            r_tick      <= w_tick_nx;
            r_settle    <= w_settle_nx;
            r_ang       <= w_ang_nx;
            r_tgt       <= w_tgt_nx;
            r_cmd_ready <= (w_state_nx == S_IDLE);
            r_busy      <= (w_state_nx != S_IDLE);
            r_done      <= (w_state_nx == S_DONE);
        end
    end

    assign angle1    = r_ang[0];
    assign angle2    = r_ang[1];
    assign angle3    = r_ang[2];
    assign angle4    = r_ang[3];
    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Bench for servo_motion_sequencer: per-scenario tasks against a trajectory
// model built from the ramp rules (step times, values, order, total latency).
module tb_servo_motion_sequencer;
    localparam int TICK_DIV      = 4;
    localparam int STEP_DEG      = 5;
    localparam int SETTLE_CYCLES = 2;
    localparam int HOME          = 90;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, abort;
    logic [7:0] tgt1, tgt2, tgt3, tgt4;
    logic [7:0] angle1, angle2, angle3, angle4;
    logic       cmd_ready, busy, done;

    int checks = 0;
    int errors = 0;
    int m_ang[4];
    int ord[4] = '{2, 0, 1, 3};

    servo_motion_sequencer #(
        .TICK_DIV(TICK_DIV), .STEP_DEG(STEP_DEG),
        .SETTLE_CYCLES(SETTLE_CYCLES), .HOME_ANGLE(HOME)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .tgt1(tgt1), .tgt2(tgt2), .tgt3(tgt3), .tgt4(tgt4), .abort(abort),
        .angle1(angle1), .angle2(angle2), .angle3(angle3), .angle4(angle4),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int obs_ang(input int j);
        case (j)
            0:       return int'(angle1);
            1:       return int'(angle2);
            2:       return int'(angle3);
            default: return int'(angle4);
        endcase
    endfunction

    function automatic int eff_tgt(input int v);
`ifdef ANGLE_CLAMP_EN
        return (v > 180) ? 180 : v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) m_ang[j] = HOME;
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s wait_ready: cmd_ready=%b required 1", name, cmd_ready);
        end
    endtask

    // Issue one command and check every angle change, done timing and ready return
    task automatic run_move(input int a1, input int a2, input int a3, input int a4,
                            input bit noise, input string name);
        int et[$], ej[$], ev[$];
        int tg[4], cur[4], prev[4];
        int t, done_t, first_done, done_cnt, nchg, o, d, s;
        tg[0] = eff_tgt(a1); tg[1] = eff_tgt(a2); tg[2] = eff_tgt(a3); tg[3] = eff_tgt(a4);
        cur = m_ang;
        t = 0;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = ord[k];
            while (cur[j] != tg[j]) begin
                d = (tg[j] > cur[j]) ? tg[j] - cur[j] : cur[j] - tg[j];
                s = (d < STEP_DEG) ? d : STEP_DEG;
                cur[j] = (tg[j] > cur[j]) ? cur[j] + s : cur[j] - s;
                t += TICK_DIV;
                et.push_back(t); ej.push_back(j); ev.push_back(cur[j]);
            end
            t += 1;
        end
        done_t = t + SETTLE_CYCLES;

        wait_ready(name);
        tgt1 = 8'(a1); tgt2 = 8'(a2); tgt3 = 8'(a3); tgt4 = 8'(a4);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b ready=%b required 1/0", name, busy, cmd_ready);
        end
        for (int j = 0; j < 4; j++) prev[j] = obs_ang(j);
        first_done = -1;
        done_cnt   = 0;
        for (int n = 1; n <= done_t + 3; n++) begin
            if (noise && n < done_t - 1) begin
                cmd_valid = 1'($urandom);
                tgt1 = 8'($urandom); tgt2 = 8'($urandom);
                tgt3 = 8'($urandom); tgt4 = 8'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            nchg = 0;
            for (int j = 0; j < 4; j++) begin
                o = obs_ang(j);
                if (o != prev[j]) begin
                    nchg++;
                    checks++;
                    if (et.size() == 0) begin
                        errors++;
                        $display("FAIL %s step: unexpected angle%0d=%0d at edge %0d", name, j + 1, o, n);
                    end else begin
                        if (et[0] != n || ej[0] != j || ev[0] != o) begin
                            errors++;
                            $display("FAIL %s step: got angle%0d=%0d at edge %0d required angle%0d=%0d at edge %0d",
                                     name, j + 1, o, n, ej[0] + 1, ev[0], et[0]);
                        end
                        void'(et.pop_front()); void'(ej.pop_front()); void'(ev.pop_front());
                    end
                    prev[j] = o;
                end
            end
            if (nchg > 1) begin
                errors++;
                $display("FAIL %s single_joint: %0d angles changed at edge %0d required 1", name, nchg, n);
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = n;
            end
            if (n == done_t || n == done_t + 1) begin
                checks++;
                if (cmd_ready !== 1'(n == done_t + 1)) begin
                    errors++;
                    $display("FAIL %s ready: cmd_ready=%b at edge %0d required %b",
                             name, cmd_ready, n, 1'(n == done_t + 1));
                end
            end
        end
        checks++;
        if (et.size() != 0) begin
            errors++;
            $display("FAIL %s missing_steps: %0d steps not seen, required 0", name, et.size());
        end
        checks++;
        if (done_cnt != 1 || first_done != done_t) begin
            errors++;
            $display("FAIL %s done: %0d pulses first at edge %0d required 1 at edge %0d",
                     name, done_cnt, first_done, done_t);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (obs_ang(j) != tg[j]) begin
                errors++;
                $display("FAIL %s final angle%0d: %0d required %0d", name, j + 1, obs_ang(j), tg[j]);
            end
        end
        m_ang = tg;
    endtask

    task automatic test_reset();
        apply_reset(3);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (obs_ang(j) != HOME) begin
                errors++;
                $display("FAIL reset angle%0d: %0d required %0d", j + 1, obs_ang(j), HOME);
            end
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset status: ready=%b busy=%b done=%b required 1/0/0", cmd_ready, busy, done);
        end
    endtask

    task automatic test_single_joint();
        run_move(90, 90, 100, 90, 1'b0, "ramp_up");
        checks++;
        if (angle3 !== 8'd100) begin
            errors++;
            $display("FAIL ramp_up angle3: %0d required 100", angle3);
        end
        apply_reset(1);
        run_move(90, 90, 88, 90, 1'b0, "no_overshoot");
    endtask

    task automatic test_all_joints();
        run_move(40, 131, 10, 172, 1'b0, "all_joints");
        run_move(40, 131, 10, 172, 1'b0, "no_motion");
        run_move(0, 255, 3, 0, 1'b0, "extremes");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++)
            run_move(int'($urandom_range(255)), int'($urandom_range(255)),
                     int'($urandom_range(255)), int'($urandom_range(255)), 1'(r % 2), "random");
    endtask

    task automatic test_abort();
        int k;
        apply_reset(1);
        wait_ready("abort");
        tgt1 = 8'd40; tgt2 = 8'd90; tgt3 = 8'd90; tgt4 = 8'd150;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        k = 0;
        while (angle1 !== 8'd70 && k < 200) begin
            tick();
            k++;
        end
        checks++;
        if (angle1 !== 8'd70) begin
            errors++;
            $display("FAIL abort reach70: angle1=%0d required 70", angle1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort busy: %b required 0", busy);
        end
        k = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (done === 1'b1) k++;
        end
        checks++;
        if (k != 0) begin
            errors++;
            $display("FAIL abort done: %0d pulses required 0", k);
        end
        m_ang[0] = 70; m_ang[1] = 90; m_ang[2] = 90; m_ang[3] = 90;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (obs_ang(j) != m_ang[j]) begin
                errors++;
                $display("FAIL abort hold angle%0d: %0d required %0d", j + 1, obs_ang(j), m_ang[j]);
            end
        end
        run_move(20, 60, 120, 90, 1'b0, "after_abort");
    endtask

    task automatic test_reset_mid_move();
        wait_ready("rst_mid");
        tgt1 = 8'd10; tgt2 = 8'd10; tgt3 = 8'd10; tgt4 = 8'd10;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (9) tick();
        abort = 1'b1;
        apply_reset(1);
        abort = 1'b0;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (obs_ang(j) != HOME) begin
                errors++;
                $display("FAIL rst_mid angle%0d: %0d required %0d", j + 1, obs_ang(j), HOME);
            end
        end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid status: busy=%b ready=%b required 0/1", busy, cmd_ready);
        end
        run_move(95, 85, 90, 100, 1'b0, "after_rst");
    endtask

    task automatic test_clamp();
        run_move(90, 90, 90, 200, 1'b0, "clamp");
        checks++;
`ifdef ANGLE_CLAMP_EN
        if (angle4 !== 8'd180) begin
            errors++;
            $display("FAIL clamp angle4: %0d required 180", angle4);
        end
`else
        if (angle4 !== 8'd200) begin
            errors++;
            $display("FAIL clamp angle4: %0d required 200", angle4);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        tgt1 = 8'd90; tgt2 = 8'd90; tgt3 = 8'd90; tgt4 = 8'd90;
        test_reset();
        test_single_joint();
        test_all_joints();
        test_random();
        test_abort();
        test_reset_mid_move();
        test_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
